// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, feeding a
// 2-entry {pc, instr} queue toward decode. Redirects flush the queue and steer
// fetch; a response to a request that was overtaken by a redirect is dropped.
//
// Handshake: dec_valid/dec_ready is strict valid/ready. A transfer happens on a
// rising edge where dec_valid=1 and dec_ready=1. dec_valid never depends on
// dec_ready. The memory side is req/ack: imem_req stays high with imem_addr
// stable until an imem_ack edge consumes the request.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] q_pc    [0:1];
    logic [31:0] q_instr [0:1];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic [1:0]  count_pop;
    logic [1:0]  count_after;
    logic        room_idle;
    logic        room_after;
    logic [31:0] rpc;
    logic [31:0] addr_inc;
    logic        unused_rpc_bits;

    // Low two redirect bits are forced to zero; keep them visibly consumed.
    assign unused_rpc_bits = ^redirect_pc[1:0];
    assign rpc             = {redirect_pc[31:2], 2'b00};
    assign addr_inc        = imem_addr + 32'd4;

    // Queue bookkeeping: pop is a decode transfer, push is a kept response.
    always_comb begin
        pop         = dec_valid & dec_ready;
        push        = (state == S_REQ) & imem_ack & ~redirect;
        count_pop   = count - {1'b0, pop};
        count_after = count_pop + {1'b0, push};
        room_idle   = 32'(count_pop) < QDEPTH;
        room_after  = 32'(count_after) < QDEPTH;
    end

    // Fetch FSM: owns the request, its address and the next fetch pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_pc  <= rpc;
                        imem_addr <= rpc;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end else if (room_idle) begin
                        imem_addr <= fetch_pc;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        fetch_pc <= rpc;
                        if (imem_ack) begin
                            // Response is stale; reissue at the target at once.
                            imem_addr <= rpc;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= addr_inc;
                        if (room_after) begin
                            imem_addr <= addr_inc;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= rpc;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect ? rpc : fetch_pc;
                        state     <= S_REQ;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction queue: 2-entry FIFO, flushed wholesale by a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                q_pc[i]    <= 32'd0;
                q_instr[i] <= 32'd0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= imem_addr;
                q_instr[wr_ptr] <= imem_rdata;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_after;
        end
    end

    assign dec_valid = (count != 2'd0);
    assign dec_pc    = q_pc[rd_ptr];
    assign dec_instr = q_instr[rd_ptr];
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural memory responder with a
// programmable ack delay, and a scoreboard of expected {pc, instr} transfers.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_delay = 1;
    int          wait_cnt = 0;
    logic [63:0] exp_q[$];
    int          xfer_cyc[$];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .dbg_state   (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, instr_of(pc)});
    endtask

    // One clock: score any transfer that the coming edge performs, then
    // advance to 1 time unit past the edge.
    task automatic tick();
        logic [63:0] e;
        if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL xfer_expected: observed pc %h, expected no transfer", dec_pc);
                end
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", dec_pc, e[63:32]);
                chk("xfer_instr", dec_instr, e[31:0]);
                xfer_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Asynchronous reset check, then release one unit after an edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, dec_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0000_1000);
        chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
        chk({tag, "_pc"}, dec_pc, 32'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Memory responder: acks after mem_delay request cycles; back-to-back
    // acks when mem_delay is 0. Cleared by reset like the real memory.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (imem_ack) begin
                if (mem_delay == 0 && imem_req) imem_rdata = instr_of(imem_addr);
                else imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (imem_req) begin
                if (wait_cnt + 1 >= mem_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = instr_of(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        dec_ready   = 1'b0;
        mem_delay   = 1;

        // Reset values, then streaming with 1-cycle memory.
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_1000);
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_instr", dec_instr, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b1;
        dec_ready = 1'b1;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_1000);
        chk("first_state", {30'd0, dbg_state}, 32'd1);
        xfer_cyc.delete();
        push_exp(32'h0000_1000);
        push_exp(32'h0000_1004);
        push_exp(32'h0000_1008);
        drain("stream_drain", 30);
        dec_ready = 1'b0;
        chk("stream_count", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() >= 3) begin
            chk("stream_gap0", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd2);
            chk("stream_gap1", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd2);
        end

        // Decode stalled, memory acking every cycle: queue fills at 2.
        mem_delay = 0;
        do_reset("rstb");
        for (int i = 0; i < 6; i++) tick();
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_state", {30'd0, dbg_state}, 32'd0);
        chk("full_valid", {31'd0, dec_valid}, 32'd1);
        chk("full_pc", dec_pc, 32'h0000_1000);
        chk("full_instr", dec_instr, instr_of(32'h0000_1000));
        for (int i = 0; i < 4; i++) tick();
        chk("full_still_idle", {31'd0, imem_req}, 32'd0);
        push_exp(32'h0000_1000);
        push_exp(32'h0000_1004);
        dec_ready = 1'b1;
        tick();
        chk("refill_req", {31'd0, imem_req}, 32'd1);
        chk("refill_addr", imem_addr, 32'h0000_1008);
        drain("full_drain", 10);
        dec_ready = 1'b0;
        chk("pushpop_valid", {31'd0, dec_valid}, 32'd1);
        chk("pushpop_pc", dec_pc, 32'h0000_1008);

        // Redirect while the 0x1008 request waits on a slow memory.
        mem_delay = 3;
        dec_ready = 1'b1;
        do_reset("rstc");
        push_exp(32'h0000_1000);
        push_exp(32'h0000_1004);
        push_exp(32'h0000_2000);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == 32'h0000_1008) found = 1'b1;
            else tick();
        end
        chk("disc_reach", {31'd0, found}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        tick();
        redirect = 1'b0;
        chk("disc_valid", {31'd0, dec_valid}, 32'd0);
        chk("disc_state", {30'd0, dbg_state}, 32'd2);
        chk("disc_req", {31'd0, imem_req}, 32'd1);
        chk("disc_addr_held", imem_addr, 32'h0000_1008);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_addr != 32'h0000_1008) found = 1'b1;
            else tick();
        end
        chk("disc_leave", {31'd0, found}, 32'd1);
        chk("disc_new_addr", imem_addr, 32'h0000_2000);
        chk("disc_new_state", {30'd0, dbg_state}, 32'd1);
        drain("disc_drain", 20);
        dec_ready = 1'b0;

        // Redirect coincident with the ack for 0x1004; 0x1000 sits queued.
        mem_delay = 1;
        do_reset("rstd");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            #2;
            if (imem_ack && imem_addr == 32'h0000_1004) found = 1'b1;
        end
        chk("ackredir_reach", {31'd0, found}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        redirect = 1'b0;
        chk("ackredir_valid", {31'd0, dec_valid}, 32'd0);
        chk("ackredir_req", {31'd0, imem_req}, 32'd1);
        chk("ackredir_addr", imem_addr, 32'h0000_3000);
        chk("ackredir_state", {30'd0, dbg_state}, 32'd1);
        push_exp(32'h0000_3000);
        dec_ready = 1'b1;
        drain("ackredir_drain", 20);
        dec_ready = 1'b0;

        // Redirect to the top word: fetch wraps to address 0.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_valid", {31'd0, dec_valid}, 32'd0);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        dec_ready = 1'b1;
        drain("wrap_drain", 30);
        dec_ready = 1'b0;

        // Reset dropped while a request is outstanding.
        mem_delay   = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        tick();
        redirect = 1'b0;
        tick();
        chk("midrst_pre_req", {31'd0, imem_req}, 32'd1);
        do_reset("midrst");
        tick();
        chk("midrst_req", {31'd0, imem_req}, 32'd1);
        chk("midrst_addr", imem_addr, 32'h0000_1000);
        mem_delay = 1;
        push_exp(32'h0000_1000);
        dec_ready = 1'b1;
        drain("midrst_drain", 20);
        dec_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
